// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges the core's instruction and data requests onto a
// single-beat cache bus. The winning request's payload is latched for the
// whole transaction. Responses are routed back combinationally as one-cycle
// data_ok pulses.
module core_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int IDATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  // instruction side
  input  logic               ireq_valid,
  input  logic [ADDR_W-1:0]  ireq_addr,
  output logic               iresp_data_ok,
  output logic [IDATA_W-1:0] iresp_data,
  // data side
  input  logic               dreq_valid,
  input  logic [ADDR_W-1:0]  dreq_addr,
  input  logic [2:0]         dreq_size,
  input  logic [7:0]         dreq_strobe,
  input  logic [DATA_W-1:0]  dreq_data,
  output logic               dresp_data_ok,
  output logic [DATA_W-1:0]  dresp_data,
  // cache bus
  output logic               creq_valid,
  output logic               creq_is_write,
  output logic [ADDR_W-1:0]  creq_addr,
  output logic [2:0]         creq_size,
  output logic [7:0]         creq_strobe,
  output logic [DATA_W-1:0]  creq_data,
  input  logic               cresp_ready,
  input  logic [DATA_W-1:0]  cresp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t              state_reg;
  logic                last_d_reg;
  logic                creq_valid_reg;
  logic [ADDR_W-1:0]   creq_addr_reg;
  logic [2:0]          creq_size_reg;
  logic [7:0]          creq_strobe_reg;
  logic [DATA_W-1:0]   creq_data_reg;

  logic                grant_d;
  logic                grant_i;
  logic [IDATA_W-1:0]  iresp_word;

  // Arbitration: data wins contention unless the previous grant was data.
  always_comb begin
    grant_d = dreq_valid & (~ireq_valid | ~last_d_reg);
    grant_i = ireq_valid & (~dreq_valid |  last_d_reg);
  end

  // Transaction FSM: latch the winner's payload, hold it until the beat completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      last_d_reg      <= 1'b0;
      creq_valid_reg  <= 1'b0;
      creq_addr_reg   <= '0;
      creq_size_reg   <= '0;
      creq_strobe_reg <= '0;
      creq_data_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg       <= DBUSY;
            last_d_reg      <= 1'b1;
            creq_valid_reg  <= 1'b1;
            creq_addr_reg   <= dreq_addr;
            creq_size_reg   <= dreq_size;
            creq_strobe_reg <= dreq_strobe;
            creq_data_reg   <= dreq_data;
          end else if (grant_i) begin
            state_reg       <= IBUSY;
            last_d_reg      <= 1'b0;
            creq_valid_reg  <= 1'b1;
            creq_addr_reg   <= ireq_addr;
            creq_size_reg   <= 3'd2;
            creq_strobe_reg <= 8'h00;
            creq_data_reg   <= '0;
          end
        end
        IBUSY, DBUSY: begin
          // Upstream inputs are deliberately ignored here: a flush may move
          // the fetch address or drop valid, but the bus beat must complete.
          if (cresp_ready) begin
            state_reg      <= IDLE;
            creq_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          creq_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Pick the 32-bit instruction word out of the 64-bit beat by address bit 2.
  for (genvar gi = 0; gi < IDATA_W; gi++) begin : g_iword
    assign iresp_word[gi] = creq_addr_reg[2] ? cresp_data[IDATA_W + gi] : cresp_data[gi];
  end

  assign iresp_data_ok = (state_reg == IBUSY) & cresp_ready;
  assign dresp_data_ok = (state_reg == DBUSY) & cresp_ready;

  // Return data is forced to zero while reset is held.
  assign iresp_data = reset ? iresp_word : '0;
  assign dresp_data = reset ? cresp_data : '0;

  assign creq_valid    = creq_valid_reg;
  assign creq_is_write = |creq_strobe_reg;
  assign creq_addr     = creq_addr_reg;
  assign creq_size     = creq_size_reg;
  assign creq_strobe   = creq_strobe_reg;
  assign creq_data     = creq_data_reg;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed vectors with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_core_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic        creq_is_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready;
  logic [63:0] cresp_data;

  int vectors;
  int miscompares;

  core_bus_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .creq_valid   (creq_valid),
    .creq_is_write(creq_is_write),
    .creq_addr    (creq_addr),
    .creq_size    (creq_size),
    .creq_strobe  (creq_strobe),
    .creq_data    (creq_data),
    .cresp_ready  (cresp_ready),
    .cresp_data   (cresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    ireq_valid  = 1'b0;
    ireq_addr   = '0;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = '0;
    dreq_strobe = '0;
    dreq_data   = '0;
    cresp_ready = 1'b1;
    cresp_data  = 64'hAAAA_BBBB_CCCC_DDDD;

    // ---- reset state (cresp driven nonzero to show output gating) ----
    cyc();
    settle();
    check_vec("rst_creq_valid", {63'd0, creq_valid}, 64'd0);
    check_vec("rst_creq_addr", creq_addr, 64'd0);
    check_vec("rst_iok", {63'd0, iresp_data_ok}, 64'd0);
    check_vec("rst_dok", {63'd0, dresp_data_ok}, 64'd0);
    check_vec("rst_idata", {32'd0, iresp_data}, 64'd0);
    check_vec("rst_ddata", dresp_data, 64'd0);
    cresp_ready = 1'b0;
    reset = 1'b1;

    // ---- single fetch, upper word ----
    cyc();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0004;
    cyc();                                // cycle 1: IBUSY
    cresp_ready = 1'b1;
    cresp_data  = 64'h1111_2222_3333_4444;
    settle();
    check_vec("f_creq_valid", {63'd0, creq_valid}, 64'd1);
    check_vec("f_creq_addr", creq_addr, 64'h8000_0004);
    check_vec("f_creq_size", {61'd0, creq_size}, 64'd2);
    check_vec("f_creq_wr", {63'd0, creq_is_write}, 64'd0);
    check_vec("f_iok", {63'd0, iresp_data_ok}, 64'd1);
    check_vec("f_dok", {63'd0, dresp_data_ok}, 64'd0);
    check_vec("f_idata", {32'd0, iresp_data}, 64'h1111_2222);
    cyc();                                // IDLE
    ireq_valid  = 1'b0;
    cresp_ready = 1'b0;
    settle();
    check_vec("f_after_valid", {63'd0, creq_valid}, 64'd0);
    check_vec("f_after_iok", {63'd0, iresp_data_ok}, 64'd0);

    // ---- data write with 3 wait cycles ----
    cyc();
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8010_0000;
    dreq_size   = 3'd2;
    dreq_strobe = 8'h0F;
    dreq_data   = 64'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 3) begin
        cresp_ready = 1'b1;
        cresp_data  = 64'h0123_4567_89AB_CDEF;
      end
      dreq_addr = 64'h9999_0000 + 64'(k);  // must not disturb the latched payload
      settle();
      check_vec($sformatf("w%0d_valid", k), {63'd0, creq_valid}, 64'd1);
      check_vec($sformatf("w%0d_wr", k), {63'd0, creq_is_write}, 64'd1);
      check_vec($sformatf("w%0d_addr", k), creq_addr, 64'h8010_0000);
      check_vec($sformatf("w%0d_strb", k), {56'd0, creq_strobe}, 64'h0F);
      check_vec($sformatf("w%0d_data", k), creq_data, 64'hDEAD_BEEF);
      check_vec($sformatf("w%0d_dok", k), {63'd0, dresp_data_ok}, (k == 3) ? 64'd1 : 64'd0);
    end
    check_vec("w_ddata", dresp_data, 64'h0123_4567_89AB_CDEF);
    cyc();
    dreq_valid  = 1'b0;
    cresp_ready = 1'b0;
    settle();
    check_vec("w_after_dok", {63'd0, dresp_data_ok}, 64'd0);
    check_vec("w_after_valid", {63'd0, creq_valid}, 64'd0);

    // ---- contention after reset: D,I,D,I ----
    do_reset();
    ireq_valid  = 1'b1;
    ireq_addr   = 64'h8000_0040;
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8020_0008;
    dreq_size   = 3'd3;
    dreq_strobe = 8'h00;
    cresp_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      settle();
      if (k % 2 == 1) begin
        logic is_d;
        is_d = (((k - 1) / 2) % 2) == 0;
        check_vec($sformatf("c%0d_valid", k), {63'd0, creq_valid}, 64'd1);
        check_vec($sformatf("c%0d_dok", k), {63'd0, dresp_data_ok}, is_d ? 64'd1 : 64'd0);
        check_vec($sformatf("c%0d_iok", k), {63'd0, iresp_data_ok}, is_d ? 64'd0 : 64'd1);
        check_vec($sformatf("c%0d_addr", k), creq_addr, is_d ? 64'h8020_0008 : 64'h8000_0040);
        check_vec($sformatf("c%0d_size", k), {61'd0, creq_size}, is_d ? 64'd3 : 64'd2);
      end else begin
        check_vec($sformatf("c%0d_idle", k), {62'd0, iresp_data_ok, dresp_data_ok}, 64'd0);
      end
      if (k == 8) begin
        ireq_valid  = 1'b0;
        dreq_valid  = 1'b0;
        cresp_ready = 1'b0;
      end
    end

    // ---- flush during IBUSY, lower word ----
    cyc();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0000;
    cyc();                                // IBUSY
    ireq_addr = 64'h8000_0100;
    settle();
    check_vec("fl_addr0", creq_addr, 64'h8000_0000);
    cyc();
    cresp_ready = 1'b1;
    cresp_data  = 64'h1111_2222_3333_4444;
    settle();
    check_vec("fl_addr1", creq_addr, 64'h8000_0000);
    check_vec("fl_iok", {63'd0, iresp_data_ok}, 64'd1);
    check_vec("fl_idata", {32'd0, iresp_data}, 64'h3333_4444);
    cyc();                                // IDLE, valid still held
    cresp_ready = 1'b0;
    settle();
    check_vec("fl_idle", {63'd0, creq_valid}, 64'd0);
    cyc();                                // new grant with the new address
    settle();
    check_vec("fl_regrant_v", {63'd0, creq_valid}, 64'd1);
    check_vec("fl_regrant_a", creq_addr, 64'h8000_0100);
    ireq_valid  = 1'b0;
    cresp_ready = 1'b1;
    cyc();
    cresp_ready = 1'b0;

    // ---- reset in the middle of DBUSY ----
    cyc();
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8030_0010;
    dreq_strobe = 8'hFF;
    cyc();                                // DBUSY, last grant = D
    settle();
    check_vec("rm_busy", {63'd0, creq_valid}, 64'd1);
    #2;
    reset       = 1'b0;
    cresp_ready = 1'b1;
    #1;
    check_vec("rm_valid", {63'd0, creq_valid}, 64'd0);
    check_vec("rm_dok", {63'd0, dresp_data_ok}, 64'd0);
    check_vec("rm_addr", creq_addr, 64'd0);
    check_vec("rm_ddata", dresp_data, 64'd0);
    cyc();
    cresp_ready = 1'b0;
    ireq_valid  = 1'b1;
    ireq_addr   = 64'h8000_0200;
    reset       = 1'b1;
    cyc();                                // both valid: D must win after reset
    settle();
    check_vec("rm_first_addr", creq_addr, 64'h8030_0010);
    cresp_ready = 1'b1;
    settle();
    check_vec("rm_first_dok", {63'd0, dresp_data_ok}, 64'd1);
    check_vec("rm_first_iok", {63'd0, iresp_data_ok}, 64'd0);
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    cyc();

    // ---- spurious ready in IDLE ----
    for (int k = 0; k < 3; k++) begin
      cyc();
      settle();
      check_vec($sformatf("sp%0d_ok", k), {62'd0, iresp_data_ok, dresp_data_ok}, 64'd0);
      check_vec($sformatf("sp%0d_valid", k), {63'd0, creq_valid}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Single-port memory-bus arbiter directly downstream of the pipeline core. It merges the core's instruction request (`ireq`/`iresp`) and data request (`dreq`/`dresp`) onto one single-beat cache bus (`creq`/`cresp`). Each granted request is latched so the downstream payload stays stable. A response is routed back to the requester with a one-cycle `data_ok` pulse.

## Interface
Parameters:
- `ADDR_W`, 64, address width of all requests.
- `DATA_W`, 64, data bus width (one beat).
- `IDATA_W`, 32, instruction return width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ireq_valid`  in  1  instruction request pending; held until `iresp_data_ok`.
- `ireq_addr`  in  ADDR_W  fetch PC, 4-byte aligned.
- `iresp_data_ok`  out  1  one-cycle pulse: fetch complete.
- `iresp_data`  out  IDATA_W  instruction word.
- `dreq_valid`  in  1  data request pending; held until `dresp_data_ok`.
- `dreq_addr`  in  ADDR_W  data address.
- `dreq_size`  in  3  log2 byte size (0..3).
- `dreq_strobe`  in  8  byte write enables; 0 means read.
- `dreq_data`  in  DATA_W  write data.
- `dresp_data_ok`  out  1  one-cycle pulse: data access complete.
- `dresp_data`  out  DATA_W  read data, raw 64-bit beat.
- `creq_valid`  out  1  downstream request valid.
- `creq_is_write`  out  1  1 when the latched strobe is nonzero.
- `creq_addr`  out  ADDR_W  latched address.
- `creq_size`  out  3  latched size; fetch uses 2.
- `creq_strobe`  out  8  latched strobe; fetch uses 0.
- `creq_data`  out  DATA_W  latched write data.
- `cresp_ready`  in  1  beat accepted and completed this cycle.
- `cresp_data`  in  DATA_W  read data, valid when `cresp_ready`.

## Operation
- FSM states are `IDLE`, `IBUSY`, `DBUSY`. One `last_d` flag records the previous grant (1 = data).
- In `IDLE`:
  - Grant data if only `dreq_valid` is set.
  - Grant instruction if only `ireq_valid` is set.
  - If both are set, grant data unless `last_d`=1, in which case grant instruction. This alternates grants under contention and prevents starvation.
- Grant effects, at the edge:
  - Latch addr, size, strobe and data from the winner into the `creq_*` registers.
  - Move to `IBUSY` or `DBUSY`.
  - Update `last_d`.
- In `IBUSY`/`DBUSY`:
  - `creq_valid`=1 and the payload is constant.
  - Upstream inputs are ignored, including addr changes and valid drops caused by flush.
  - On `cresp_ready` the FSM returns to `IDLE`.
- Response routing is combinational:
  - `iresp_data_ok` = `IBUSY` & `cresp_ready`.
  - `dresp_data_ok` = `DBUSY` & `cresp_ready`.
  - `iresp_data` = `cresp_data[63:32]` if latched `addr[2]`=1, else `cresp_data[31:0]`.
  - `dresp_data` = `cresp_data` unmodified.
- Fetch payload: `creq_size`=2, `creq_strobe`=0, `creq_is_write`=0.
- Only one transaction is outstanding. There are no bursts and no pipelining of requests.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to `IDLE`, `last_d`=0, and all `creq_*` registers clear to 0.
  - `creq_valid`=0, both `data_ok`=0, both `resp_data`=0 immediately.
- Reset mid-transaction drops the transaction. No `data_ok` is issued for it.
- Minimum latency is 2 cycles from request to `data_ok`:
  - Cycle 0: `IDLE` samples the request.
  - Cycle 1: busy state with `creq_valid`, and `cresp_ready` arrives the same cycle.
- Each cycle without `cresp_ready` adds one cycle of latency. There is no timeout.
- `cresp_ready` outside the busy states is ignored.
- A requester whose `valid` is still high in the cycle after `data_ok` starts a new transaction. This is required for the core's always-valid fetch.
- Back-to-back transactions therefore occupy at least 2 cycles each, because of one `IDLE` cycle between them.
- Requests arriving during a busy state wait. They are not queued beyond the held `valid`.

## Test plan
- Single fetch:
  - Stimulus: `ireq_valid`=1, addr=0x8000_0004; `cresp_ready`=1 in cycle 1 with `cresp_data`=0x1111_2222_3333_4444.
  - Required: `creq_addr`=0x8000_0004, `creq_size`=2 in cycle 1; `iresp_data_ok` pulses in cycle 1 with `iresp_data`=0x1111_2222.
- Data write:
  - Stimulus: `dreq_valid`, addr=0x8010_0000, strobe=0x0F, data=0xDEAD_BEEF; ready delayed 3 cycles.
  - Required: `creq_is_write`=1 and payload stable for 4 cycles; single `dresp_data_ok` pulse.
- Contention:
  - Stimulus: `ireq_valid` and `dreq_valid` both held continuously, immediate ready.
  - Required: grants alternate D,I,D,I starting with D after reset; no two consecutive I grants.
- Flush during busy:
  - Stimulus: in `IBUSY`, change `ireq_addr` from 0x8000_0000 to 0x8000_0100, then ready.
  - Required: `creq_addr` stays 0x8000_0000; the next grant uses 0x8000_0100.
- Reset mid-op:
  - Stimulus: assert `reset`=0 asynchronously in `DBUSY` between edges.
  - Required: `creq_valid` drops the same cycle; no `dresp_data_ok`; after release the first contention grant is D.
- Spurious ready:
  - Stimulus: `cresp_ready`=1 in `IDLE` with no requests.
  - Required: no `data_ok`; state stays `IDLE`.
